// File: rtl/spi_node.sv
// spi_node: single-clock SPI endpoint; p_master strap selects master (drives cs/mosi)
// or slave (drives miso while selected). Received bytes come out with a one-cycle valid.
module spi_node #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sck,
    input  logic                  reset,
    input  logic                  p_master,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    inout  wire                   cs,
    inout  wire                   mosi,
    inout  wire                   miso,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  p_valid
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    typedef enum logic {IDLE, XFER} state_t;
    state_t                r_state, w_state_nx;
    logic                  r_cs, w_cs_nx, w_load, w_last, w_in, w_cs_low, w_rx_done;
    logic [DATA_WIDTH-1:0] r_tx_sh, w_tx_nx, r_stx_sh, w_rx_nx;
    logic [DATA_WIDTH-2:0] r_rx_sh;
    logic [CW-1:0]         r_cnt, w_cnt_nx, r_rcnt;
    assign cs       = p_master ? r_cs : 1'bz;
    assign mosi     = p_master ? (r_state == XFER && r_tx_sh[DATA_WIDTH-1]) : 1'bz;
    assign miso     = (!p_master && w_cs_low) ? r_stx_sh[DATA_WIDTH-1] : 1'bz;
    // Both roles key their receive path off the shared cs net, not the master's own register.
    assign w_cs_low  = (cs == 1'b0);
    assign w_in      = p_master ? miso : mosi;
    assign w_rx_nx   = {r_rx_sh, w_in};
    assign w_rx_done = w_cs_low && r_rcnt == LAST;
    always_comb begin
        w_load     = r_state == IDLE;
        w_last     = r_state == XFER && r_cnt == LAST;
        w_tx_nx    = w_load ? p_data_in : r_tx_sh << 1;
        w_cnt_nx   = w_load ? '0 : r_cnt + 1'b1;
        w_cs_nx    = w_load ? 1'b0 : (w_last ? 1'b1 : r_cs);
        w_state_nx = w_load ? XFER : (w_last ? IDLE : r_state);
    end
    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cs    <= 1'b1;
            r_tx_sh <= '0;
            r_cnt   <= '0;
        end else if (p_master) begin
            r_state <= w_state_nx;
            r_cs    <= w_cs_nx;
            r_tx_sh <= w_tx_nx;
            r_cnt   <= w_cnt_nx;
        end
    end
    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            r_rx_sh    <= '0;
            r_rcnt     <= '0;
            r_stx_sh   <= '0;
            p_data_out <= '0;
            p_valid    <= 1'b0;
        end else begin
            p_valid  <= w_rx_done;
            r_rcnt   <= (w_cs_low && !w_rx_done) ? r_rcnt + 1'b1 : '0;
            r_stx_sh <= w_cs_low ? r_stx_sh << 1 : p_data_in;
            if (w_cs_low) r_rx_sh <= w_rx_nx[DATA_WIDTH-2:0];
            if (w_rx_done) p_data_out <= w_rx_nx;
        end
    end
endmodule

// File: tb/tb_spi_node.sv
// tb_spi_node: master + slave on a shared bus plus an isolated slave on pulled-up nets.
module tb_spi_node;
    localparam int DW = 8;
    typedef struct packed {
        logic [7:0] m;
        logic [7:0] s;
    } vec_t;
    logic       sck = 1'b0, rst_m = 1'b1, rst_s = 1'b1;
    logic [7:0] m_din = '0, s_din = '0, m_out, s_out, iso_out, last_m = '0;
    logic       m_valid, s_valid, iso_valid;
    bit         mon_en = 1'b0;
    wire        cs, mosi, miso, iso_cs, iso_mosi, iso_miso;
    vec_t       sb[$];
    vec_t       tbl[6];
    vec_t       exp_v;
    int         n_chk = 0, n_fail = 0;
    pullup (miso);
    pullup (iso_cs);
    pullup (iso_mosi);
    pullup (iso_miso);
    spi_node #(.DATA_WIDTH(DW)) u_m (.sck(sck), .reset(rst_m), .p_master(1'b1), .p_data_in(m_din),
        .cs(cs), .mosi(mosi), .miso(miso), .p_data_out(m_out), .p_valid(m_valid));
    spi_node #(.DATA_WIDTH(DW)) u_s (.sck(sck), .reset(rst_s), .p_master(1'b0), .p_data_in(s_din),
        .cs(cs), .mosi(mosi), .miso(miso), .p_data_out(s_out), .p_valid(s_valid));
    spi_node #(.DATA_WIDTH(DW)) u_iso (.sck(sck), .reset(rst_s), .p_master(1'b0), .p_data_in(s_din),
        .cs(iso_cs), .mosi(iso_mosi), .miso(iso_miso), .p_data_out(iso_out), .p_valid(iso_valid));
    always #5 sck = ~sck;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Released pins read 1 through the pullups, so any stray driver shows up as a value change.
    always @(negedge sck) if (mon_en) begin
        if (cs == 1'b1) chk("miso_z_cs_high", {7'b0, miso}, 8'd1);
        chk("iso_cs_z", {7'b0, iso_cs}, 8'd1);
        chk("iso_mosi_z", {7'b0, iso_mosi}, 8'd1);
        chk("iso_miso_z", {7'b0, iso_miso}, 8'd1);
        chk("iso_no_valid", {7'b0, iso_valid}, 8'd0);
        if (m_valid || s_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", {6'b0, m_valid, s_valid}, 8'd0);
            else begin
                exp_v = sb.pop_front();
                chk("valid_pair", {6'b0, m_valid, s_valid}, 8'd3);
                chk("slave_rx", s_out, exp_v.m);
                chk("master_rx", m_out, exp_v.s);
            end
        end
    end
    task automatic reset_checks();
        chk("rst_cs", {7'b0, cs}, 8'd1);
        chk("rst_mosi", {7'b0, mosi}, 8'd0);
        chk("rst_m_valid", {7'b0, m_valid}, 8'd0);
        chk("rst_s_valid", {7'b0, s_valid}, 8'd0);
        chk("rst_m_out", m_out, 8'h00);
        chk("rst_s_out", s_out, 8'h00);
    endtask
    // Entered in the master's IDLE cycle; returns in the next IDLE cycle.
    task automatic run_frame(input logic [7:0] m, input logic [7:0] s, input int chg_at, input logic [7:0] chg_val);
        chk("cs_idle", {7'b0, cs}, 8'd1);
        m_din = m;
        s_din = s;
        sb.push_back({m, s});
        last_m = m;
        for (int i = 0; i < DW; i++) begin
            @(negedge sck);
            if (i == chg_at) m_din = chg_val;
            chk("cs_low", {7'b0, cs}, 8'd0);
            chk("mosi_bit", {7'b0, mosi}, {7'b0, m[7-i]});
            chk("valid_low_in_frame", {6'b0, m_valid, s_valid}, 8'd0);
        end
        @(negedge sck);
        chk("valid_at_idle", {6'b0, m_valid, s_valid}, 8'd3);
    endtask
    initial begin
        tbl[0] = {8'hE9, 8'h5A};
        tbl[1] = {8'h3C, 8'hC3};
        tbl[2] = {8'h00, 8'hFF};
        tbl[3] = {8'hFF, 8'h00};
        tbl[4] = {8'hA5, 8'h5A};
        tbl[5] = {8'h81, 8'h7E};
        mon_en = 1'b1;
        m_din  = 8'hE9;
        s_din  = 8'h5A;
        repeat (3) begin
            @(negedge sck);
            reset_checks();
        end
        rst_m = 1'b0;
        rst_s = 1'b0;
        run_frame(8'hE9, 8'h5A, -1, 8'h00);
        run_frame(8'hE9, 8'h5A, -1, 8'h00);
        run_frame(8'hE9, 8'h5A, 3, 8'h3C);
        run_frame(8'h3C, 8'h5A, -1, 8'h00);
        foreach (tbl[i]) run_frame(tbl[i].m, tbl[i].s, -1, 8'h00);
        chk("cs_idle_abort", {7'b0, cs}, 8'd1);
        m_din = 8'hE9;
        s_din = 8'h5A;
        repeat (5) begin
            @(negedge sck);
            chk("cs_low_abort", {7'b0, cs}, 8'd0);
        end
        #1 rst_m = 1'b1;
        #1 chk("cs_async_high", {7'b0, cs}, 8'd1);
        @(negedge sck);
        chk("abort_cs", {7'b0, cs}, 8'd1);
        chk("abort_mosi", {7'b0, mosi}, 8'd0);
        chk("abort_s_valid", {7'b0, s_valid}, 8'd0);
        chk("abort_s_keep", s_out, last_m);
        chk("abort_m_out", m_out, 8'h00);
        rst_m = 1'b0;
        run_frame(8'hE9, 8'h5A, -1, 8'h00);
        #1 rst_m = 1'b1;
        rst_s = 1'b1;
        repeat (3) begin
            @(negedge sck);
            reset_checks();
        end
        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
